bullet_collision_detector: RTL and testbench
============================================

BULLET_COLLISION_DETECTOR -- requirements
Module: bullet_collision_detector

Interface
REQ-001 Parameters (name, default, meaning):
- PLAYER_W, 8, player box width in pixels.
- PLAYER_H, 8, player box height in pixels.
- BULLET_W, 2, bullet width in pixels.
- BULLET_H, 4, bullet height in pixels.
- MAX_HP, 20, HP loaded on reset/restart (max 31).
- DAMAGE, 4, HP removed per hit.
- HOLD_CYCLES, 4, cycles player_collision is held per hit.
- INVULN_CYCLES, 50_000_000, post-hit invulnerability length (≤ 2^26-1).

REQ-002 Ports (name, direction, width, meaning):
- CLOCK_50 input 1: single clock, rising edge.
- resetn input 1: reset, asynchronous, active-low.
- enable input 1: gameplay running.
- restart input 1: one-cycle request to start a new round.
- bullet_x input 8: bullet top-left x.
- bullet_y input 7: bullet top-left y.
- bullet_active input 1: bullet on screen.
- player_x input 8: player top-left x.
- player_y input 7: player top-left y.
- player_collision output 1: hit indication back to the bullet generator.
- hit_pulse output 1: one-cycle strobe per accepted hit.
- player_hp output 5: current HP.
- invulnerable output 1: high in INVULN.
- game_over output 1: high in DEAD.

Function
REQ-003 Overlap term, combinational: bullet_active AND bx < px+PLAYER_W AND bx+BULLET_W > px AND by < py+PLAYER_H AND by+BULLET_H > py. Compute x sums in 9 bits and y sums in 8 bits so nothing wraps.
REQ-004 The overlap term SHALL be registered into overlap_q every cycle, whatever enable is.
REQ-005 FSM states: ARMED, HIT, INVULN, DEAD. All outputs are registered.
REQ-006 ARMED, enable=1 and overlap_q=1: at that edge
- go to HIT;
- player_hp <= max(player_hp-DAMAGE, 0), saturating;
- hit_pulse=1 for exactly one cycle;
- load the hold counter.
Latency from sampled overlapping inputs to player_collision=1 is 2 clock edges.
REQ-007 ARMED, enable=0: no detection, HP unchanged.
REQ-008 HIT: player_collision=1 for exactly HOLD_CYCLES enabled cycles. Then:
- player_hp==0 -> DEAD;
- otherwise -> INVULN, loading the INVULN_CYCLES counter.
REQ-009 INVULN: invulnerable=1 and overlap_q is ignored. After INVULN_CYCLES enabled cycles -> ARMED.
REQ-010 HIT and INVULN counters SHALL freeze while enable=0, with state and outputs held.
REQ-011 DEAD: game_over=1 and player_collision=1, held steady until restart or reset, regardless of enable.
REQ-012 restart=1 in any state, at the next edge:
- player_hp <= MAX_HP;
- state -> ARMED;
- counters, hit_pulse, player_collision, invulnerable and game_over cleared.
restart has priority over a simultaneous overlap or counter expiry.
REQ-013 A continuous overlap SHALL produce one hit per ARMED entry, never one per cycle.
REQ-014 A hit with DAMAGE ≥ player_hp SHALL leave player_hp=0 and lead to DEAD, never wrap.
REQ-015 player_collision SHALL be high only in HIT or DEAD.

Reset
REQ-016 On resetn=0, asynchronously:
- state=ARMED;
- player_hp=MAX_HP;
- overlap_q=0 and counters=0;
- player_collision=0, hit_pulse=0, invulnerable=0, game_over=0.
REQ-017 Reset mid-HIT or mid-INVULN SHALL abandon the sequence immediately, with no further hit_pulse.

Verification (bench overrides HOLD_CYCLES=4, INVULN_CYCLES=10)
REQ-018 Stimulus: player (70,100), bullet (71,98) active, enable=1.
- hit_pulse high exactly 1 cycle, 2 edges after stimulus;
- player_hp 20->16;
- player_collision high 4 cycles;
- invulnerable high 10 cycles.
REQ-019 Same geometry with bullet_active=0, or bullet at (78,100) (touching edge only, bx = px+PLAYER_W) -> no hit, HP stays 20.
REQ-020 Overlap held continuously for 100 cycles -> hits occur once per ARMED re-entry (every 15 cycles after the first). No hit ever occurs in INVULN.
REQ-021 HP=4, DAMAGE=4, hit -> player_hp=0. After 4 cycles game_over=1 and player_collision=1 and stay high. restart pulse -> player_hp=20, ARMED, game_over=0.
REQ-022 enable dropped for 20 cycles mid-INVULN -> counter frozen; invulnerable stays high. Total invulnerable time = 10 enabled cycles.
REQ-023 resetn asserted mid-HIT -> all outputs at REQ-016 values with no clock edge; player_hp=20 after release.

Source files
------------

// File: rtl/bullet_collision_detector.sv
// Bullet/player box overlap detector with HP bookkeeping, a timed hit hold,
// post-hit invulnerability and a sticky game-over state.
module bullet_collision_detector #(
  parameter int unsigned PLAYER_W      = 8,
  parameter int unsigned PLAYER_H      = 8,
  parameter int unsigned BULLET_W      = 2,
  parameter int unsigned BULLET_H      = 4,
  parameter int unsigned MAX_HP        = 20,
  parameter int unsigned DAMAGE        = 4,
  parameter int unsigned HOLD_CYCLES   = 4,
  parameter int unsigned INVULN_CYCLES = 50_000_000
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic       enable,
  input  logic       restart,
  input  logic [7:0] bullet_x,
  input  logic [6:0] bullet_y,
  input  logic       bullet_active,
  input  logic [7:0] player_x,
  input  logic [6:0] player_y,
  output logic       player_collision,
  output logic       hit_pulse,
  output logic [4:0] player_hp,
  output logic       invulnerable,
  output logic       game_over
);

  localparam int unsigned CntW = 26;
  localparam logic [CntW-1:0] HoldLoad   = CntW'(HOLD_CYCLES - 1);
  localparam logic [CntW-1:0] InvulnLoad = CntW'(INVULN_CYCLES - 1);
  localparam logic [4:0]      MaxHp      = 5'(MAX_HP);

  typedef enum logic [1:0] {StArmed, StHit, StInvuln, StDead} state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic            overlap_d, overlap_q;
  logic            x_ok, y_ok;
  logic [4:0]      hp_after_hit;

  // Widened sums so boxes near the right/bottom screen edge never wrap.
  assign x_ok = ({1'b0, bullet_x} < ({1'b0, player_x} + 9'(PLAYER_W))) &&
                (({1'b0, bullet_x} + 9'(BULLET_W)) > {1'b0, player_x});
  assign y_ok = ({1'b0, bullet_y} < ({1'b0, player_y} + 8'(PLAYER_H))) &&
                (({1'b0, bullet_y} + 8'(BULLET_H)) > {1'b0, player_y});
  assign overlap_d = bullet_active && x_ok && y_ok;

  assign hp_after_hit = (32'(player_hp) > DAMAGE) ? (player_hp - 5'(DAMAGE)) : 5'd0;

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q          <= StArmed;
      cnt_q            <= '0;
      overlap_q        <= 1'b0;
      player_hp        <= MaxHp;
      player_collision <= 1'b0;
      hit_pulse        <= 1'b0;
      invulnerable     <= 1'b0;
      game_over        <= 1'b0;
    end else begin
      overlap_q <= overlap_d;
      hit_pulse <= 1'b0;
      if (restart) begin
        state_q          <= StArmed;
        cnt_q            <= '0;
        player_hp        <= MaxHp;
        player_collision <= 1'b0;
        invulnerable     <= 1'b0;
        game_over        <= 1'b0;
      end else begin
        case (state_q)
          StArmed: begin
            if (enable && overlap_q) begin
              state_q          <= StHit;
              player_hp        <= hp_after_hit;
              hit_pulse        <= 1'b1;
              player_collision <= 1'b1;
              cnt_q            <= HoldLoad;
            end
          end
          StHit: begin
            if (enable) begin
              if (cnt_q == '0) begin
                if (player_hp == 5'd0) begin
                  // Collision stays asserted so the bullet generator sees a dead player.
                  state_q   <= StDead;
                  game_over <= 1'b1;
                end else begin
                  state_q          <= StInvuln;
                  player_collision <= 1'b0;
                  invulnerable     <= 1'b1;
                  cnt_q            <= InvulnLoad;
                end
              end else begin
                cnt_q <= cnt_q - 1'b1;
              end
            end
          end
          StInvuln: begin
            if (enable) begin
              if (cnt_q == '0) begin
                state_q      <= StArmed;
                invulnerable <= 1'b0;
              end else begin
                cnt_q <= cnt_q - 1'b1;
              end
            end
          end
          StDead: begin
          end
          default: state_q <= StArmed;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bullet_collision_detector.sv
// Directed plus randomized check of bullet_collision_detector against a
// timer-based behavioural model of the hit/invulnerability rules.
module tb_bullet_collision_detector;

  localparam int HOLD  = 4;
  localparam int INV   = 10;
  localparam int MAXHP = 20;
  localparam int DMG   = 4;

  logic       CLOCK_50 = 1'b0;
  logic       resetn;
  logic       enable;
  logic       restart;
  logic [7:0] bullet_x;
  logic [6:0] bullet_y;
  logic       bullet_active;
  logic [7:0] player_x;
  logic [6:0] player_y;
  logic       player_collision;
  logic       hit_pulse;
  logic [4:0] player_hp;
  logic       invulnerable;
  logic       game_over;

  int errors = 0;
  int checks = 0;

  // Model: remaining hold / invulnerability time, dead flag, HP, delayed overlap.
  int m_hp, m_hold, m_inv;
  bit m_dead, m_pulse, m_ovq;

  bullet_collision_detector #(
    .HOLD_CYCLES  (HOLD),
    .INVULN_CYCLES(INV)
  ) dut (
    .CLOCK_50        (CLOCK_50),
    .resetn          (resetn),
    .enable          (enable),
    .restart         (restart),
    .bullet_x        (bullet_x),
    .bullet_y        (bullet_y),
    .bullet_active   (bullet_active),
    .player_x        (player_x),
    .player_y        (player_y),
    .player_collision(player_collision),
    .hit_pulse       (hit_pulse),
    .player_hp       (player_hp),
    .invulnerable    (invulnerable),
    .game_over       (game_over)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic bit model_overlap();
    return bullet_active &&
           (int'(bullet_x) < int'(player_x) + 8) && (int'(bullet_x) + 2 > int'(player_x)) &&
           (int'(bullet_y) < int'(player_y) + 8) && (int'(bullet_y) + 4 > int'(player_y));
  endfunction

  function automatic void model_reset();
    m_hp = MAXHP; m_hold = 0; m_inv = 0; m_dead = 0; m_pulse = 0; m_ovq = 0;
  endfunction

  function automatic void model_edge();
    bit ov;
    ov = model_overlap();
    m_pulse = 0;
    if (restart) begin
      m_hp = MAXHP; m_hold = 0; m_inv = 0; m_dead = 0;
    end else if (m_dead) begin
    end else if (m_hold > 0) begin
      if (enable) begin
        m_hold--;
        if (m_hold == 0) begin
          if (m_hp == 0) m_dead = 1;
          else m_inv = INV;
        end
      end
    end else if (m_inv > 0) begin
      if (enable) m_inv--;
    end else if (enable && m_ovq) begin
      m_hp    = (m_hp > DMG) ? m_hp - DMG : 0;
      m_hold  = HOLD;
      m_pulse = 1;
    end
    m_ovq = ov;
  endfunction

  task automatic check_all();
    chk("hp", 32'(player_hp), 32'(m_hp));
    chk("hit_pulse", 32'(hit_pulse), 32'(m_pulse));
    chk("collision", 32'(player_collision), 32'((m_hold > 0) || m_dead));
    chk("invulnerable", 32'(invulnerable), 32'(m_inv > 0));
    chk("game_over", 32'(game_over), 32'(m_dead));
  endtask

  task automatic tick();
    @(posedge CLOCK_50);
    if (!resetn) model_reset();
    else model_edge();
    #1;
    check_all();
  endtask

  task automatic set_geom(input int px, input int py, input int bx, input int by, input bit act);
    player_x = 8'(px); player_y = 7'(py);
    bullet_x = 8'(bx); bullet_y = 7'(by);
    bullet_active = act;
  endtask

  task automatic do_restart();
    restart = 1'b1;
    tick();
    restart = 1'b0;
  endtask

  initial begin
    int first, pulses, coll, inv, last_hit, gap, found;
    resetn = 1'b0; enable = 1'b1; restart = 1'b0;
    set_geom(70, 100, 0, 0, 0);
    model_reset();
    repeat (2) @(posedge CLOCK_50);
    #1;
    check_all();
    resetn = 1'b1;

    // Single hit: latency, damage, hold and invulnerability lengths.
    set_geom(70, 100, 71, 98, 1);
    first = -1; pulses = 0; coll = 0; inv = 0;
    for (int k = 1; k <= 15; k++) begin
      tick();
      if (hit_pulse && first < 0) first = k;
      pulses += int'(hit_pulse); coll += int'(player_collision); inv += int'(invulnerable);
    end
    chk("hit_latency", 32'(first), 32'd2);
    chk("hit_count_single", 32'(pulses), 32'd1);
    chk("hp_after_hit", 32'(player_hp), 32'd16);
    chk("collision_cycles", 32'(coll), 32'(HOLD));
    chk("invuln_cycles", 32'(inv), 32'(INV));

    // Inactive bullet and edge-touching bullet never hit.
    bullet_active = 1'b0;
    do_restart();
    pulses = 0;
    repeat (20) begin tick(); pulses += int'(hit_pulse); end
    set_geom(70, 100, 78, 100, 1);
    repeat (20) begin tick(); pulses += int'(hit_pulse); end
    chk("no_hit_pulses", 32'(pulses), 32'd0);
    chk("no_hit_hp", 32'(player_hp), 32'd20);

    // Continuous overlap: one hit per ARMED entry, then death and restart.
    bullet_active = 1'b0;
    do_restart();
    set_geom(70, 100, 71, 98, 1);
    pulses = 0; last_hit = 0; gap = 0;
    for (int k = 1; k <= 60; k++) begin
      tick();
      if (hit_pulse) begin
        pulses++; gap = k - last_hit; last_hit = k;
      end
    end
    chk("continuous_hits", 32'(pulses), 32'd4);
    chk("hit_period", 32'(gap), 32'd15);
    chk("hp_before_last", 32'(player_hp), 32'd4);
    repeat (10) tick();
    chk("dead_hp", 32'(player_hp), 32'd0);
    chk("dead_game_over", 32'(game_over), 32'd1);
    chk("dead_collision", 32'(player_collision), 32'd1);
    enable = 1'b0;
    repeat (5) tick();
    chk("dead_sticky", 32'(game_over), 32'd1);
    enable = 1'b1;
    do_restart();
    chk("restart_hp", 32'(player_hp), 32'd20);
    chk("restart_game_over", 32'(game_over), 32'd0);

    // Enable dropped mid-invulnerability freezes the timer.
    bullet_active = 1'b0;
    found = 0;
    for (int k = 0; k < 20 && found == 0; k++) begin
      tick();
      if (invulnerable) found = 1;
    end
    chk("invuln_reached", 32'(found), 32'd1);
    inv = 1;
    repeat (3) begin tick(); inv += int'(invulnerable); end
    enable = 1'b0;
    repeat (20) begin tick(); inv += int'(invulnerable); end
    enable = 1'b1;
    repeat (20) begin tick(); inv += int'(invulnerable); end
    chk("invuln_frozen_total", 32'(inv), 32'd30);

    // Asynchronous reset mid-HIT.
    set_geom(70, 100, 71, 98, 1);
    do_restart();
    bullet_active = 1'b0;
    found = 0;
    for (int k = 0; k < 10 && found == 0; k++) begin
      tick();
      if (player_collision) found = 1;
    end
    chk("hit_reached", 32'(found), 32'd1);
    resetn = 1'b0;
    #2;
    model_reset();
    check_all();
    #2;
    resetn = 1'b1;
    tick();
    chk("post_reset_hp", 32'(player_hp), 32'd20);

    // Randomized geometry, enable and restart.
    for (int k = 0; k < 2000; k++) begin
      int px, py;
      enable  = ($urandom_range(0, 9) != 0);
      restart = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 7) == 0) begin
        set_geom(int'($urandom_range(0, 255)), int'($urandom_range(0, 127)),
                 int'($urandom_range(0, 255)), int'($urandom_range(0, 127)),
                 1'($urandom_range(0, 1)));
      end else begin
        px = int'($urandom_range(10, 240));
        py = int'($urandom_range(10, 115));
        set_geom(px, py, px + int'($urandom_range(0, 20)) - 10,
                 py + int'($urandom_range(0, 16)) - 6, ($urandom_range(0, 3) != 0));
      end
      tick();
    end
    restart = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
